// File: rtl/ahb_default_slave_errlog_if.sv
// AHB-Lite bus bundle for the default slave: address/control from the master
// side, ready/response/read data back from the slave.
`timescale 1ns/1ps
interface ahb_default_slave_errlog_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_default_slave_errlog.sv
// AHB-Lite default slave for unmapped regions: optional wait states, then an
// ERROR (or read-as-zero OKAY) response, plus a first-fault log with IRQ.
`timescale 1ns/1ps
module ahb_default_slave_errlog #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int RESP_MODE   = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_default_slave_errlog_if.slave ahb,
    input  logic                  FAULT_CLEAR,
    output logic                  FAULT_VALID,
    output logic [ADDR_WIDTH-1:0] FAULT_ADDR,
    output logic                  FAULT_WRITE,
    output logic [2:0]            FAULT_SIZE,
    output logic                  FAULT_OVERFLOW,
    output logic [CNT_WIDTH-1:0]  FAULT_COUNT,
    output logic                  IRQ
);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15 || CNT_WIDTH < 1 || CNT_WIDTH > 16 ||
            (RESP_MODE != 0 && RESP_MODE != 1)) begin : g_bad_param
            $error("ahb_default_slave_errlog: illegal WAIT_STATES, CNT_WIDTH or RESP_MODE");
        end
    endgenerate

    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam bit         ERR_MODE  = (RESP_MODE == 0);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        ready_q;
    logic        resp_q;
    logic        req;
    logic        valid_base;
    logic        ovf_base;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic        unused_htrans0;

    assign req            = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign unused_htrans0 = ahb.HTRANS[0];

    // Output flops are loaded together with the next state so HREADYOUT/HRESP
    // are a pure function of the state register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (req && HAS_WAIT) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                        ready_q  <= 1'b0;
                        resp_q   <= 1'b0;
                    end else if (req && ERR_MODE) begin
                        state   <= ST_ERR1;
                        ready_q <= 1'b0;
                        resp_q  <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (ERR_MODE) begin
                        state   <= ST_ERR1;
                        ready_q <= 1'b0;
                        resp_q  <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ahb.HREADYOUT = ready_q;
    assign ahb.HRESP     = resp_q;
    assign ahb.HRDATA    = 32'd0;

    // A clear takes effect first, so a coincident request is logged as a fresh first fault.
    assign valid_base = FAULT_VALID & ~FAULT_CLEAR;
    assign ovf_base   = FAULT_OVERFLOW & ~FAULT_CLEAR;
    assign cnt_base   = FAULT_CLEAR ? '0 : FAULT_COUNT;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            FAULT_VALID    <= 1'b0;
            FAULT_OVERFLOW <= 1'b0;
            FAULT_COUNT    <= '0;
            FAULT_ADDR     <= '0;
            FAULT_WRITE    <= 1'b0;
            FAULT_SIZE     <= 3'd0;
        end else begin
            FAULT_VALID    <= valid_base | req;
            FAULT_OVERFLOW <= ovf_base | (req & valid_base);
            if (req) begin
                FAULT_COUNT <= (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
            end else begin
                FAULT_COUNT <= cnt_base;
            end
            if (req && !valid_base) begin
                FAULT_ADDR  <= ahb.HADDR;
                FAULT_WRITE <= ahb.HWRITE;
                FAULT_SIZE  <= ahb.HSIZE;
            end
        end
    end

    assign IRQ = FAULT_VALID;

endmodule

// File: tb/tb_ahb_default_slave_errlog.sv
// Scoreboard bench: five differently parameterised slaves share one stimulus
// driver; a negedge monitor checks every data phase against queued expectations.
`timescale 1ns/1ps
module tb_ahb_default_slave_errlog;

    localparam int NDUT = 5;
    localparam int WS_TAB [NDUT] = '{0, 3, 15, 2, 0};
    localparam int RM_TAB [NDUT] = '{0, 0, 0, 1, 1};
    localparam int CW_TAB [NDUT] = '{2, 8, 8, 8, 8};

    typedef struct {
        int   waits;
        logic err;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    int          sel = 0;
    logic        hsel_d = 1'b0;
    logic [31:0] haddr_d = 32'd0;
    logic [1:0]  htrans_d = 2'b00;
    logic        hwrite_d = 1'b0;
    logic [2:0]  hsize_d = 3'd0;
    logic        fclr_d = 1'b0;

    logic        rdyA   [NDUT];
    logic        respA  [NDUT];
    logic [31:0] rdataA [NDUT];
    logic        validA [NDUT];
    logic [31:0] addrA  [NDUT];
    logic        writeA [NDUT];
    logic [2:0]  sizeA  [NDUT];
    logic        ovfA   [NDUT];
    logic [31:0] countA [NDUT];
    logic        irqA   [NDUT];

    exp_t expQ [$];
    int   checks = 0;
    int   errors = 0;
    bit   inData = 1'b0;
    int   waitCnt = 0;
    int   errCnt = 0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CW = CW_TAB[g];
        ahb_default_slave_errlog_if #(.ADDR_WIDTH(32)) bus ();
        logic [CW-1:0] cnt;

        assign bus.HSEL   = hsel_d && (sel == g);
        assign bus.HADDR  = haddr_d;
        assign bus.HTRANS = htrans_d;
        assign bus.HWRITE = hwrite_d;
        assign bus.HSIZE  = hsize_d;
        assign bus.HREADY = bus.HREADYOUT;

        ahb_default_slave_errlog #(
            .ADDR_WIDTH (32),
            .WAIT_STATES(WS_TAB[g]),
            .RESP_MODE  (RM_TAB[g]),
            .CNT_WIDTH  (CW)
        ) dut (
            .HCLK          (HCLK),
            .HRESET        (HRESET),
            .ahb           (bus),
            .FAULT_CLEAR   (fclr_d && (sel == g)),
            .FAULT_VALID   (validA[g]),
            .FAULT_ADDR    (addrA[g]),
            .FAULT_WRITE   (writeA[g]),
            .FAULT_SIZE    (sizeA[g]),
            .FAULT_OVERFLOW(ovfA[g]),
            .FAULT_COUNT   (cnt),
            .IRQ           (irqA[g])
        );

        assign rdyA[g]   = bus.HREADYOUT;
        assign respA[g]  = bus.HRESP;
        assign rdataA[g] = bus.HRDATA;
        assign countA[g] = 32'(cnt);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: tracks the data phase of the selected slave and scores each completion.
    always @(negedge HCLK) begin
        if (HRESET) begin
            inData = 1'b0;
        end else begin
            if (inData) begin
                if (!rdyA[sel]) begin
                    if (respA[sel]) errCnt++;
                    else waitCnt++;
                end else begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        checkOutput("wait_cycles", 32'(waitCnt), 32'(e.waits));
                        checkOutput("hresp", {31'd0, respA[sel]}, {31'd0, e.err});
                        checkOutput("err1_cycles", 32'(errCnt), e.err ? 32'd1 : 32'd0);
                        checkOutput("hrdata", rdataA[sel], 32'd0);
                    end
                    inData = 1'b0;
                end
            end else begin
                checkOutput("idle_hreadyout", {31'd0, rdyA[sel]}, 32'd1);
                checkOutput("idle_hresp", {31'd0, respA[sel]}, 32'd0);
            end
            if (!inData && hsel_d && htrans_d[1] && rdyA[sel]) begin
                inData  = 1'b1;
                waitCnt = 0;
                errCnt  = 0;
            end
        end
    end

    task automatic idleBus();
        hsel_d   = 1'b0;
        htrans_d = 2'b00;
    endtask

    // Drives one NONSEQ address phase and returns just after the edge that accepts it.
    task automatic applyStimulus(input int dut, input logic [31:0] addr, input logic wr,
                                 input logic [2:0] size, input logic clr,
                                 input int expWaits, input logic expErr);
        bit accepted = 1'b0;
        sel      = dut;
        hsel_d   = 1'b1;
        haddr_d  = addr;
        htrans_d = 2'b10;
        hwrite_d = wr;
        hsize_d  = size;
        fclr_d   = clr;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge HCLK);
            accepted = rdyA[dut];
            @(posedge HCLK);
            #1;
        end
        fclr_d = 1'b0;
        checkOutput("accept", {31'd0, accepted}, 32'd1);
        if (accepted) expQ.push_back('{expWaits, expErr});
    endtask

    task automatic driveNoReq(input int dut, input logic s, input logic [1:0] t);
        sel      = dut;
        hsel_d   = s;
        htrans_d = t;
        haddr_d  = 32'hDEAD_0000;
        @(posedge HCLK);
        #1;
        idleBus();
    endtask

    task automatic pulseClear(input int dut);
        sel    = dut;
        fclr_d = 1'b1;
        @(posedge HCLK);
        #1;
        fclr_d = 1'b0;
    endtask

    task automatic waitDone();
        bit done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (expQ.size() == 0 && !inData) done = 1'b1;
            else begin
                @(posedge HCLK);
                #1;
            end
        end
        checkOutput("drain", {31'd0, done}, 32'd1);
    endtask

    task automatic checkLog(input string tag, input logic v, input logic [31:0] a,
                            input logic w, input logic [2:0] s, input logic o, input int c);
        checkOutput({tag, "_valid"}, {31'd0, validA[sel]}, {31'd0, v});
        checkOutput({tag, "_addr"}, addrA[sel], a);
        checkOutput({tag, "_write"}, {31'd0, writeA[sel]}, {31'd0, w});
        checkOutput({tag, "_size"}, {29'd0, sizeA[sel]}, {29'd0, s});
        checkOutput({tag, "_overflow"}, {31'd0, ovfA[sel]}, {31'd0, o});
        checkOutput({tag, "_count"}, countA[sel], 32'(c));
        checkOutput({tag, "_irq"}, {31'd0, irqA[sel]}, {31'd0, v});
    endtask

    // Asserts reset mid-response and checks the selected slave drops to its reset state at once.
    task automatic applyReset(input string tag);
        HRESET = 1'b1;
        expQ.delete();
        #1;
        checkOutput({tag, "_hreadyout"}, {31'd0, rdyA[sel]}, 32'd1);
        checkOutput({tag, "_hresp"}, {31'd0, respA[sel]}, 32'd0);
        checkLog(tag, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        sel = 0;
        checkOutput("reset_hreadyout", {31'd0, rdyA[0]}, 32'd1);
        checkOutput("reset_hresp", {31'd0, respA[0]}, 32'd0);
        checkLog("reset", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Zero-wait ERROR slave: single write fault
        applyStimulus(0, 32'h4000_1000, 1'b1, 3'd2, 1'b0, 0, 1'b1);
        idleBus();
        waitDone();
        checkLog("t1", 1'b1, 32'h4000_1000, 1'b1, 3'd2, 1'b0, 1);

        pulseClear(0);
        checkLog("clear", 1'b0, 32'h4000_1000, 1'b1, 3'd2, 1'b0, 0);

        // Back-to-back faults: second issued while the first is in ERR2
        applyStimulus(0, 32'h0000_0010, 1'b0, 3'd0, 1'b0, 0, 1'b1);
        applyStimulus(0, 32'h0000_0020, 1'b1, 3'd2, 1'b0, 0, 1'b1);
        idleBus();
        waitDone();
        checkLog("b2b", 1'b1, 32'h0000_0010, 1'b0, 3'd0, 1'b1, 2);

        driveNoReq(0, 1'b1, 2'b00);
        driveNoReq(0, 1'b1, 2'b01);
        driveNoReq(0, 1'b0, 2'b10);
        waitDone();
        checkOutput("noreq_count", countA[0], 32'd2);

        // Two-bit counter saturates at 3 after five faults
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0000_0100 + 32'(i * 4), 1'b0, 3'd2, 1'b0, 0, 1'b1);
        end
        idleBus();
        waitDone();
        checkLog("sat", 1'b1, 32'h0000_0010, 1'b0, 3'd0, 1'b1, 3);

        applyStimulus(0, 32'h0000_0030, 1'b1, 3'd1, 1'b1, 0, 1'b1);
        idleBus();
        waitDone();
        checkLog("clr_req", 1'b1, 32'h0000_0030, 1'b1, 3'd1, 1'b0, 1);

        // Wait-state boundaries in ERROR mode
        applyStimulus(1, 32'h5000_0000, 1'b0, 3'd2, 1'b0, 3, 1'b1);
        idleBus();
        waitDone();
        checkLog("ws3", 1'b1, 32'h5000_0000, 1'b0, 3'd2, 1'b0, 1);

        applyStimulus(2, 32'h6000_0004, 1'b1, 3'd1, 1'b0, 15, 1'b1);
        idleBus();
        waitDone();
        checkLog("ws15", 1'b1, 32'h6000_0004, 1'b1, 3'd1, 1'b0, 1);

        // Read-as-zero mode with and without wait states
        applyStimulus(3, 32'h8000_0000, 1'b0, 3'd2, 1'b0, 2, 1'b0);
        idleBus();
        waitDone();
        checkLog("raz_ws2", 1'b1, 32'h8000_0000, 1'b0, 3'd2, 1'b0, 1);

        applyStimulus(4, 32'h8000_0010, 1'b0, 3'd2, 1'b0, 0, 1'b0);
        applyStimulus(4, 32'h8000_0020, 1'b0, 3'd2, 1'b0, 0, 1'b0);
        idleBus();
        waitDone();
        checkLog("raz_ws0", 1'b1, 32'h8000_0010, 1'b0, 3'd2, 1'b1, 2);

        // Reset during ERR1, then normal operation
        applyStimulus(0, 32'h0000_0044, 1'b1, 3'd2, 1'b0, 0, 1'b1);
        idleBus();
        applyReset("rst_err1");
        applyStimulus(0, 32'h0000_0048, 1'b0, 3'd2, 1'b0, 0, 1'b1);
        idleBus();
        waitDone();
        checkLog("post_rst0", 1'b1, 32'h0000_0048, 1'b0, 3'd2, 1'b0, 1);

        // Reset during WAIT, then normal operation
        applyStimulus(1, 32'h5000_0100, 1'b1, 3'd2, 1'b0, 3, 1'b1);
        idleBus();
        @(posedge HCLK);
        #1;
        applyReset("rst_wait");
        applyStimulus(1, 32'h5000_0200, 1'b0, 3'd2, 1'b0, 3, 1'b1);
        idleBus();
        waitDone();
        checkLog("post_rst1", 1'b1, 32'h5000_0200, 1'b0, 3'd2, 1'b0, 1);

        repeat (2) @(posedge HCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_default_slave_errlog.md
Name: ahb_default_slave_errlog

Overview:
Parametrised AHB-Lite default slave for unmapped address regions. Inserts a configurable number of wait states and then returns either a two-cycle ERROR response or, in read-as-zero mode, an OKAY response. Captures the first faulting transfer, counts all faulting transfers, and raises a level interrupt for system software. Sits on the AHB decoder's default-select output, beside the bus multiplexor.

Parameters:
ADDR_WIDTH, 32, width of HADDR and FAULT_ADDR
WAIT_STATES, 0, wait cycles inserted before the response; legal range 0..15
RESP_MODE, 0, 0 = ERROR response; 1 = OKAY response with read data zero and writes discarded
CNT_WIDTH, 8, width of the saturating fault counter; legal range 1..16

Ports:
HCLK  input  1  clock
HRESET  input  1  asynchronous reset, active-high
HSEL  input  1  slave select
HADDR  input  ADDR_WIDTH  address
HTRANS  input  2  transfer type
HWRITE  input  1  write flag
HSIZE  input  3  transfer size
HREADY  input  1  system ready
HREADYOUT  output  1  slave ready
HRESP  output  1  slave response (1 = ERROR)
HRDATA  output  32  read data; tied to 0
FAULT_CLEAR  input  1  single-cycle pulse that clears the fault log
FAULT_VALID  output  1  fault log holds a captured transfer
FAULT_ADDR  output  ADDR_WIDTH  HADDR of the first logged fault
FAULT_WRITE  output  1  HWRITE of the first logged fault
FAULT_SIZE  output  3  HSIZE of the first logged fault
FAULT_OVERFLOW  output  1  at least one further fault arrived while FAULT_VALID was 1
FAULT_COUNT  output  CNT_WIDTH  count of faulting transfers, saturating
IRQ  output  1  equals FAULT_VALID

Behaviour:
- Request: req = HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers are never requests.
- Reset: asynchronous. While HRESET is 1, the FSM is in IDLE, HREADYOUT=1, HRESP=0, and all FAULT_* outputs and IRQ are 0. Reset asserted mid-response aborts the response immediately.
- FSM states: IDLE, WAIT, ERR1, ERR2. Outputs are registered and decoded from state only.
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- IDLE, or ERR2, with req:
  - WAIT_STATES>0: go to WAIT and load the 4-bit wait counter with WAIT_STATES-1.
  - WAIT_STATES=0 and RESP_MODE=0: go to ERR1.
  - WAIT_STATES=0 and RESP_MODE=1: stay in IDLE, giving a zero-wait OKAY completion.
- IDLE, or ERR2, without req: go to (or stay in) IDLE.
- WAIT: decrement the counter each cycle. When the counter is 0, leave WAIT: to ERR1 if RESP_MODE=0, to IDLE if RESP_MODE=1. Result: exactly WAIT_STATES cycles with HREADYOUT=0 and HRESP=0.
- ERR1 always goes to ERR2. A transfer seen in ERR2 with HREADY=1 starts a new back-to-back response.
- Requests are ignored in WAIT and ERR1. HREADY is low then whenever this slave is selected.
- HRDATA is 0 in all states. Write data is discarded.
- Fault log (both modes), updated on the clock edge that samples req:
  - FAULT_VALID=0: capture HADDR, HWRITE and HSIZE; set FAULT_VALID.
  - FAULT_VALID=1: captured fields are held; set FAULT_OVERFLOW.
  - FAULT_COUNT increments on every req and saturates at all-ones, never wrapping.
- FAULT_CLEAR without req: FAULT_VALID, FAULT_OVERFLOW and FAULT_COUNT go to 0. FAULT_ADDR, FAULT_WRITE and FAULT_SIZE hold their stale values.
- FAULT_CLEAR with req in the same cycle: the clear applies first and the new fault is then logged. Result: FAULT_VALID=1, new address captured, FAULT_OVERFLOW=0, FAULT_COUNT=1.
- IRQ is a level signal equal to FAULT_VALID. It falls the cycle after FAULT_CLEAR unless a req coincides with the clear.
- Invalid WAIT_STATES or CNT_WIDTH values must fail at elaboration.

Test Plan:
1. RESP_MODE=0, WAIT_STATES=0: NONSEQ write to 0x4000_1000 -> HREADYOUT/HRESP = 0/1 then 1/1, then back to 1/0. FAULT_VALID=1, FAULT_ADDR=0x4000_1000, FAULT_WRITE=1, IRQ=1, FAULT_COUNT=1.
2. WAIT_STATES=3, RESP_MODE=0: a single NONSEQ -> 3 cycles of 0/0, then 0/1, then 1/1. Repeat with WAIT_STATES=0 and 15 to check the boundaries.
3. RESP_MODE=1, WAIT_STATES=2: a read -> 2 wait cycles, then HREADYOUT=1, HRESP=0, HRDATA=0. Log updated as in test 1. With WAIT_STATES=0 the slave is zero-wait and never drops HREADYOUT.
4. Back-to-back: a second NONSEQ to 0x20 issued during ERR2 of a fault to 0x10 -> immediate ERR1/ERR2 again. FAULT_ADDR stays 0x10, FAULT_OVERFLOW=1, FAULT_COUNT=2. IDLE and BUSY transfers and HSEL=0 -> no response and no count.
5. CNT_WIDTH=2: 5 faults -> FAULT_COUNT saturates at 3. FAULT_CLEAR alone -> VALID, OVERFLOW, COUNT and IRQ go to 0. FAULT_CLEAR coinciding with a req to 0x30 -> VALID=1, ADDR=0x30, OVERFLOW=0, COUNT=1.
6. HRESET pulsed during ERR1 or WAIT -> HREADYOUT=1, HRESP=0 and all log outputs 0 immediately. Normal operation resumes after release.
